// File: rtl/number_entry_buffer.sv
// Keypad entry register: builds an N-digit decimal/hex operand and keeps its binary value,
// digit nibbles and a space-padded ASCII string. DEL re-derives the value over several cycles.
module number_entry_buffer #(
  parameter int DIGITS  = 6,
  parameter int VALUE_W = 20
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mode,
  input  logic [4:0]                  key_code,
  input  logic                        key_valid,
  output logic                        key_ready,
  output logic [VALUE_W-1:0]          value,
  output logic                        value_valid,
  output logic [4*DIGITS-1:0]         digits,
  output logic [$clog2(DIGITS+1)-1:0] count,
  output logic [8*DIGITS-1:0]         ascii,
  output logic                        reject
);
  localparam int CW = $clog2(DIGITS+1);
  localparam int PW = VALUE_W + 5;
  localparam logic [CW-1:0] FULL = CW'(DIGITS);
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic {IDLE, CONV} state_t;
  state_t state, state_next;

  logic                mode_q;
  logic [PW-1:0]       acc;
  logic [CW-1:0]       conv_left;
  logic [CW-1:0]       conv_idx;
  logic [3:0]          d;
  logic [3:0]          conv_digit;
  logic [3:0]          nib;
  logic [PW-1:0]       digit_prod;
  logic [PW-1:0]       conv_prod;
  logic [4*DIGITS-1:0] digits_push;
  logic mode_change, accept, is_digit, do_clr, do_del, del_to_conv;
  logic digit_bad, do_reject, digit_take, conv_last;

  // Radix-10 multiply stays shift-and-add so no multiplier is inferred.
  function automatic logic [PW-1:0] mul_add(input logic [PW-1:0] v, input logic hex,
                                            input logic [3:0] dig);
    logic [PW-1:0] dx;
    dx = {{(PW-4){1'b0}}, dig};
    if (hex) mul_add = (v << 4) + dx;
    else     mul_add = (v << 3) + (v << 1) + dx;
  endfunction

  assign mode_change = (mode != mode_q);
  assign accept      = key_valid && (state == IDLE) && !mode_change;
  assign d           = key_code[3:0];
  assign is_digit    = accept && !key_code[4];
  assign do_clr      = accept && (key_code == 5'd16);
  assign do_del      = accept && (key_code == 5'd17) && (count != '0);
  assign del_to_conv = do_del && (count != ONE);

  assign digit_prod  = mul_add({5'b0, value}, mode, d);
  assign digit_bad   = (!mode && (d > 4'd9)) || (count == FULL) || (digit_prod[PW-1:VALUE_W] != '0);
  assign do_reject   = is_digit && digit_bad;
  assign digit_take  = is_digit && !digit_bad && !((d == 4'd0) && (count == '0));

  // Re-conversion walks the surviving digits from the most significant one down.
  assign conv_idx    = conv_left - ONE;
  assign conv_digit  = digits[{conv_idx, 2'b00} +: 4];
  assign conv_prod   = mul_add(acc, mode, conv_digit);
  assign conv_last   = (state == CONV) && (conv_left == ONE);

  always_comb begin
    digits_push      = digits << 4;
    digits_push[3:0] = d;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (mode_change) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (del_to_conv) state_next = CONV;
        CONV: if (conv_last)   state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    key_ready   = (state == IDLE);
    value_valid = (state == IDLE);
  end

  // A radix change invalidates the entry, so it clears everything and wins over any key.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q    <= mode;
      digits    <= '0;
      count     <= '0;
      value     <= '0;
      acc       <= '0;
      conv_left <= '0;
      reject    <= 1'b0;
    end else begin
      mode_q <= mode;
      reject <= do_reject;
      if (mode_change) begin
        digits    <= '0;
        count     <= '0;
        value     <= '0;
        acc       <= '0;
        conv_left <= '0;
      end else if (do_clr) begin
        digits <= '0;
        count  <= '0;
        value  <= '0;
      end else if (digit_take) begin
        digits <= digits_push;
        count  <= count + ONE;
        value  <= digit_prod[VALUE_W-1:0];
      end else if (do_del) begin
        digits <= digits >> 4;
        count  <= count - ONE;
        if (del_to_conv) begin
          acc       <= '0;
          conv_left <= count - ONE;
        end else begin
          value <= '0;
        end
      end else if (state == CONV) begin
        acc       <= conv_prod;
        conv_left <= conv_left - ONE;
        if (conv_last) value <= conv_prod[VALUE_W-1:0];
      end
    end
  end

  // An empty entry still shows a single "0" in the least-significant position.
  always_comb begin
    nib = '0;
    for (int i = 0; i < DIGITS; i++) begin
      nib = digits[4*i +: 4];
      if (CW'(i) < count)
        ascii[8*i +: 8] = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
      else
        ascii[8*i +: 8] = 8'h20;
    end
    if (count == '0) ascii[7:0] = 8'h30;
  end

endmodule
